// File: rtl/axi_10g_ethernet_0_arp_rx_parser.sv
// axi_10g_ethernet_0_arp_rx_parser: decodes ARP requests on the 10G MAC RX stream and
// hands qualified requester MAC/IP to the ARP reply generator.
module axi_10g_ethernet_0_arp_rx_parser #(
  parameter logic [47:0] BOARD_MAC = 48'h02_00_c0_a8_0a_0a,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd2, 8'd20}
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [63:0] rx_axis_tdata,
  input  logic [7:0]  rx_axis_tkeep,
  input  logic        rx_axis_tvalid,
  input  logic        rx_axis_tlast,
  input  logic        rx_axis_tuser,
  input  logic        arp_reply_done,
  output logic        tx_arp_en,
  output logic [47:0] arp_src_mac,
  output logic [31:0] arp_src_ip,
  output logic [15:0] arp_req_cnt,
  output logic [15:0] arp_drop_cnt
);
  typedef enum logic [1:0] {IDLE, PARSE, TAIL, DISCARD} state_t;
  localparam logic [47:0] MAC_W = {BOARD_MAC[7:0], BOARD_MAC[15:8], BOARD_MAC[23:16],
                                   BOARD_MAC[31:24], BOARD_MAC[39:32], BOARD_MAC[47:40]};
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        match_q, busy_q, tx_en_q;
  logic [47:0] sha_q, mac_q;
  logic [31:0] spa_q, ip_q;
  logic [15:0] req_q, drop_q;
  logic        beat_ok, m, eval, accept, drop, cap2, cap3;
  logic        unused_ok;
  wire  [63:0] d = rx_axis_tdata;
  wire         v = rx_axis_tvalid;
  wire         l = rx_axis_tlast;
  assign unused_ok = ^rx_axis_tkeep[7:2];
  // Per-beat field checks, bytes in wire order (byte n at d[8n+7:8n])
  always_comb begin
    beat_ok = (cnt_q == 3'd0) ? (d[47:0] == 48'hFFFF_FFFF_FFFF || d[47:0] == MAC_W) :
              (cnt_q == 3'd1) ? (d[63:32] == 32'h0100_0608) :
              (cnt_q == 3'd2) ? (d[47:0] == 48'h0100_0406_0008) :
              (cnt_q == 3'd4) ? (d[63:48] == {BOARD_IP[23:16], BOARD_IP[31:24]}) :
              (cnt_q == 3'd5) ? (d[15:0] == {BOARD_IP[7:0], BOARD_IP[15:8]} && rx_axis_tkeep[1:0] == 2'b11) :
              1'b1;
    m = ((state_q == IDLE) ? 1'b1 : match_q) & beat_ok;
    cnt_d = !v ? cnt_q : l ? 3'd0 : (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;
  end
  always_ff @(posedge aclk)
    if (areset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (v)
      case (state_q)
        IDLE:    state_d = l ? IDLE : m ? PARSE : DISCARD;
        PARSE:   state_d = l ? IDLE : !m ? DISCARD : (cnt_q == 3'd5) ? TAIL : PARSE;
        default: state_d = l ? IDLE : state_q;
      endcase
  end
  always_comb begin
    eval   = v & l & ((state_q == PARSE & cnt_q == 3'd5 & m) | state_q == TAIL);
    accept = eval & rx_axis_tuser & (!busy_q | arp_reply_done);
    drop   = eval & !accept;
    cap2   = v & state_q == PARSE & cnt_q == 3'd2;
    cap3   = v & state_q == PARSE & cnt_q == 3'd3;
  end
  always_ff @(posedge aclk)
    if (areset) begin
      cnt_q   <= '0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      tx_en_q <= 1'b0;
      sha_q   <= '0;
      spa_q   <= '0;
      mac_q   <= '0;
      ip_q    <= '0;
      req_q   <= '0;
      drop_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      match_q <= v ? m : match_q;
      busy_q  <= accept | (busy_q & !arp_reply_done);
      tx_en_q <= accept;
      if (cap2) sha_q[15:0] <= d[63:48];
      if (cap3) sha_q[47:16] <= d[31:0];
      if (cap3) spa_q <= d[63:32];
      if (accept) mac_q <= sha_q;
      if (accept) ip_q <= spa_q;
      if (accept && req_q != 16'hFFFF) req_q <= req_q + 16'd1;
      if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  assign tx_arp_en    = tx_en_q;
  assign arp_src_mac  = mac_q;
  assign arp_src_ip   = ip_q;
  assign arp_req_cnt  = req_q;
  assign arp_drop_cnt = drop_q;
endmodule

// File: tb/tb_axi_10g_ethernet_0_arp_rx_parser.sv
// tb_axi_10g_ethernet_0_arp_rx_parser: directed ARP frames with a queue-based scoreboard
// checking every tx_arp_en pulse for timing, requester MAC/IP and request count.
module tb_axi_10g_ethernet_0_arp_rx_parser;
  logic        clk = 1'b0, rst = 1'b1;
  logic [63:0] tdata = '0;
  logic [7:0]  tkeep = '0;
  logic        tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0, done = 1'b0;
  logic        tx_en;
  logic [47:0] src_mac;
  logic [31:0] src_ip;
  logic [15:0] req_cnt, drop_cnt;
  int          cyc = 0, ncmp = 0, nbad = 0;
  typedef struct {logic [47:0] mac; logic [31:0] ip; logic [15:0] cnt; int cyc;} exp_t;
  exp_t q[$];
  exp_t e;
  localparam logic [47:0] BC = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] TPA_OK = 32'hc0a8_0214;
  axi_10g_ethernet_0_arp_rx_parser dut (
    .aclk(clk), .areset(rst), .rx_axis_tdata(tdata), .rx_axis_tkeep(tkeep),
    .rx_axis_tvalid(tvalid), .rx_axis_tlast(tlast), .rx_axis_tuser(tuser),
    .arp_reply_done(done), .tx_arp_en(tx_en), .arp_src_mac(src_mac), .arp_src_ip(src_ip),
    .arp_req_cnt(req_cnt), .arp_drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    ncmp++;
    if (a !== x) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", n, a, x);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0 && cyc == q[0].cyc) begin
      e = q.pop_front();
      chk("tx_arp_en", {63'd0, tx_en}, 64'd1);
      chk("arp_src_mac", {16'd0, src_mac}, {16'd0, e.mac});
      chk("arp_src_ip", {32'd0, src_ip}, {32'd0, e.ip});
      chk("arp_req_cnt", {48'd0, req_cnt}, {48'd0, e.cnt});
    end else if (tx_en)
      chk("unexpected_tx_arp_en", 64'd1, 64'd0);
  end
  task automatic send(input logic [47:0] dst, input logic [15:0] et, input logic [15:0] op,
                      input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa,
                      input int nb, input bit tu, input int gap_after, input bit done_last,
                      input bit xp, input logic [47:0] emac, input logic [31:0] eip,
                      input logic [15:0] ecnt);
    logic [7:0] b [64];
    exp_t x;
    for (int i = 0; i < 64; i++) b[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      b[i]      = dst[47-8*i -: 8];
      b[6+i]    = 8'h02 + 8'(i);
      b[22+i]   = sha[47-8*i -: 8];
    end
    b[12] = et[15:8];  b[13] = et[7:0];
    b[14] = 8'h00;     b[15] = 8'h01;
    b[16] = 8'h08;     b[17] = 8'h00;
    b[18] = 8'h06;     b[19] = 8'h04;
    b[20] = op[15:8];  b[21] = op[7:0];
    for (int i = 0; i < 4; i++) begin
      b[28+i] = spa[31-8*i -: 8];
      b[38+i] = tpa[31-8*i -: 8];
    end
    for (int k = 0; k < nb; k++) begin
      if (k == gap_after + 1)
        repeat (3) begin
          @(negedge clk);
          tvalid = 1'b0;
        end
      @(negedge clk);
      for (int j = 0; j < 8; j++) tdata[8*j +: 8] = b[8*k+j];
      tkeep  = 8'hFF;
      tvalid = 1'b1;
      tlast  = (k == nb - 1);
      tuser  = tlast ? tu : 1'b0;
      done   = tlast & done_last;
      if (tlast && xp) begin
        x.mac = emac; x.ip = eip; x.cnt = ecnt; x.cyc = cyc + 1;
        q.push_back(x);
      end
    end
    @(negedge clk);
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; done = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic pulse_done();
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask
  task automatic cnts(input string n, input logic [15:0] r, input logic [15:0] dr);
    chk({n, "_req_cnt"}, {48'd0, req_cnt}, {48'd0, r});
    chk({n, "_drop_cnt"}, {48'd0, drop_cnt}, {48'd0, dr});
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_arp_en", {63'd0, tx_en}, 64'd0);
    chk("rst_src_mac", {16'd0, src_mac}, 64'd0);
    chk("rst_src_ip", {32'd0, src_ip}, 64'd0);
    cnts("rst", 16'd0, 16'd0);
    // Broadcast request from 00:11:22:33:44:55 / 192.168.2.100
    send(BC, 16'h0806, 16'h0001, 48'h0011_2233_4455, 32'hc0a8_0264, TPA_OK, 8, 1'b1, -1, 1'b0,
         1'b1, 48'h5544_3322_1100, 32'h6402_a8c0, 16'd1);
    cnts("a", 16'd1, 16'd0);
    pulse_done();
    send(BC, 16'h0806, 16'h0001, 48'h0011_2233_4455, 32'hc0a8_0264, 32'hc0a8_0215, 8, 1'b1, -1, 1'b0,
         1'b0, '0, '0, '0);
    cnts("wrong_tpa", 16'd1, 16'd0);
    send(BC, 16'h0806, 16'h0002, 48'h0011_2233_4455, 32'hc0a8_0264, TPA_OK, 8, 1'b1, -1, 1'b0,
         1'b0, '0, '0, '0);
    cnts("oper2", 16'd1, 16'd0);
    send(BC, 16'h0800, 16'h0001, 48'h0011_2233_4455, 32'hc0a8_0264, TPA_OK, 8, 1'b1, -1, 1'b0,
         1'b0, '0, '0, '0);
    cnts("ipv4", 16'd1, 16'd0);
    send(BC, 16'h0806, 16'h0001, 48'h0011_2233_4455, 32'hc0a8_0264, TPA_OK, 8, 1'b0, -1, 1'b0,
         1'b0, '0, '0, '0);
    cnts("bad_fcs", 16'd1, 16'd1);
    // Back-to-back: second is dropped while busy
    send(BC, 16'h0806, 16'h0001, 48'h0a0b_0c0d_0e0f, 32'h0a00_0001, TPA_OK, 8, 1'b1, -1, 1'b0,
         1'b1, 48'h0f0e_0d0c_0b0a, 32'h0100_000a, 16'd2);
    send(BC, 16'h0806, 16'h0001, 48'haabb_ccdd_eeff, 32'hc0a8_0203, TPA_OK, 8, 1'b1, -1, 1'b0,
         1'b0, '0, '0, '0);
    cnts("busy", 16'd2, 16'd2);
    chk("busy_hold_mac", {16'd0, src_mac}, {16'd0, 48'h0f0e_0d0c_0b0a});
    chk("busy_hold_ip", {32'd0, src_ip}, {32'd0, 32'h0100_000a});
    pulse_done();
    send(BC, 16'h0806, 16'h0001, 48'h1122_3344_5566, 32'hc0a8_0201, TPA_OK, 8, 1'b1, -1, 1'b0,
         1'b1, 48'h6655_4433_2211, 32'h0102_a8c0, 16'd3);
    // Unicast to the board MAC, reply_done coincident with tlast while busy
    send(48'h0200_c0a8_0a0a, 16'h0806, 16'h0001, 48'h0011_2233_4455, 32'hc0a8_0264, TPA_OK, 8, 1'b1,
         -1, 1'b1, 1'b1, 48'h5544_3322_1100, 32'h6402_a8c0, 16'd4);
    cnts("coincident", 16'd4, 16'd2);
    pulse_done();
    send(BC, 16'h0806, 16'h0001, 48'hdead_beef_0001, 32'hc0a8_0207, TPA_OK, 8, 1'b1, 2, 1'b0,
         1'b1, 48'h0100_efbe_adde, 32'h0702_a8c0, 16'd5);
    pulse_done();
    send(BC, 16'h0806, 16'h0001, 48'h0011_2233_4455, 32'hc0a8_0264, TPA_OK, 4, 1'b1, -1, 1'b0,
         1'b0, '0, '0, '0);
    cnts("runt", 16'd5, 16'd2);
    chk("runt_hold_mac", {16'd0, src_mac}, {16'd0, 48'h0100_efbe_adde});
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
